// File: rtl/soc_event_dc_tx_if.sv
// soc_event_dc_tx_if: event handshake and token/data bus of the SoC-side event crossing.
//   slave  : the transmit block (takes events and read tokens, drives ready, write tokens, slot data, fill)
//   master : the event source plus the cluster receiver
interface soc_event_dc_tx_if #(
    parameter int BUFFER_WIDTH = 8,
    parameter int EVNT_WIDTH   = 8
);
    logic                               evt_valid_i;
    logic [EVNT_WIDTH-1:0]              evt_data_i;
    logic                               evt_ready_o;
    logic [BUFFER_WIDTH-1:0]            events_wt_o;
    logic [BUFFER_WIDTH-1:0]            events_rp_i;
    logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] events_da_o;
    logic [$clog2(BUFFER_WIDTH):0]      fill_o;
    modport slave (
        input  evt_valid_i, evt_data_i, events_rp_i,
        output evt_ready_o, events_wt_o, events_da_o, fill_o
    );
    modport master (
        output evt_valid_i, evt_data_i, events_rp_i,
        input  evt_ready_o, events_wt_o, events_da_o, fill_o
    );
endinterface

// File: rtl/soc_event_dc_tx.sv
// soc_event_dc_tx: SoC-side transmit half of the SoC-to-cluster event crossing.
//   clk_i : SoC clock, the only clock here
//   rst_i : asynchronous active-high reset
//   bus   : slave side of soc_event_dc_tx_if (event valid/ready/data in, toggle write
//           tokens and slot contents out, cluster read tokens in, occupied-slot count out)
module soc_event_dc_tx #(
    parameter int BUFFER_WIDTH = 8,
    parameter int EVNT_WIDTH   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    soc_event_dc_tx_if.slave     bus
);
    localparam int IW = $clog2(BUFFER_WIDTH);
    localparam int FW = IW + 1;
    logic [BUFFER_WIDTH-1:0]            r_wt;
    logic [BUFFER_WIDTH-1:0]            r_rp_q1;
    logic [BUFFER_WIDTH-1:0]            r_rp_s;
    logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] r_mem;
    logic [IW-1:0]                      r_wr_idx;
    logic [FW-1:0]                      r_fill;
    logic [BUFFER_WIDTH-1:0]            w_occ;
    logic [FW-1:0]                      w_cnt;
    logic                               w_ready;
    logic                               w_push;
    // a slot is occupied while our write token differs from the synchronised read token
    assign w_occ   = r_wt ^ r_rp_s;
    assign w_ready = !w_occ[r_wr_idx];
    assign w_push  = bus.evt_valid_i && w_ready;
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < BUFFER_WIDTH; i++)
            w_cnt = w_cnt + FW'(w_occ[i]);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wt     <= '0;
            r_rp_q1  <= '0;
            r_rp_s   <= '0;
            r_mem    <= '0;
            r_wr_idx <= '0;
            r_fill   <= '0;
        end else begin
            r_rp_q1 <= bus.events_rp_i;
            r_rp_s  <= r_rp_q1;
            r_fill  <= w_cnt;
            // data and token move on the same edge; the receiver's token synchroniser
            // delays its view of the token, so the data is settled before it is read
            if (w_push) begin
                r_mem[r_wr_idx*EVNT_WIDTH +: EVNT_WIDTH] <= bus.evt_data_i;
                r_wt[r_wr_idx] <= ~r_wt[r_wr_idx];
                r_wr_idx <= (r_wr_idx == IW'(BUFFER_WIDTH-1)) ? '0 : r_wr_idx + 1'b1;
            end
        end
    end
    assign bus.evt_ready_o = w_ready;
    assign bus.events_wt_o = r_wt;
    assign bus.events_da_o = r_mem;
    assign bus.fill_o      = r_fill;
endmodule

// File: tb/tb_soc_event_dc_tx.sv
// tb_soc_event_dc_tx: self-checking bench for soc_event_dc_tx against a push/credit count model.
module tb_soc_event_dc_tx;
    localparam int BW = 8;
    localparam int EW = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    soc_event_dc_tx_if #(.BUFFER_WIDTH(BW), .EVNT_WIDTH(EW)) bus();
    soc_event_dc_tx #(.BUFFER_WIDTH(BW), .EVNT_WIDTH(EW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // model: P events accepted so far, C releases driven by the consumer,
    // Cd1/Cs the release count as seen one and two edges later
    int P, C, Cd1, Cs, m_fill, now;
    logic [EW-1:0] pushed[$];
    int ptime[$];
    bit accepted;
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            v;
        logic [EW-1:0] d;
        bit            r;
        logic [BW-1:0] wt;
        int            f;
    } vec_t;
    vec_t tbl[10];

    function automatic logic [BW-1:0] tok(int n);
        logic [BW-1:0] r;
        for (int i = 0; i < BW; i++)
            r[i] = (((n / BW) + ((i < n % BW) ? 1 : 0)) % 2) == 1;
        return r;
    endfunction

    function automatic logic [BW*EW-1:0] m_da();
        logic [BW*EW-1:0] r = '0;
        for (int i = 0; i < BW; i++)
            if (P > i) r[i*EW +: EW] = pushed[((P - 1 - i) / BW) * BW + i];
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_c(int c);
        C = c;
        bus.events_rp_i = tok(c);
    endtask

    task automatic tick();
        int occ;
        logic [BW-1:0] prev_wt;
        occ = P - Cs;
        prev_wt = bus.events_wt_o;
        @(posedge clk_i);
        accepted = bus.evt_valid_i && (occ < BW);
        m_fill = occ;
        if (accepted) begin
            pushed.push_back(bus.evt_data_i);
            ptime.push_back(now);
            P++;
        end
        Cs = Cd1;
        Cd1 = C;
        now++;
        #2;
        chk("ready", 64'(bus.evt_ready_o), 64'((P - Cs) < BW));
        chk("wt", 64'(bus.events_wt_o), 64'(tok(P)));
        chk("da", bus.events_da_o, m_da());
        chk("fill", 64'(bus.fill_o), 64'(m_fill));
        chk("wt_1bit", 64'($countones(bus.events_wt_o ^ prev_wt) <= 1), 64'(1));
    endtask

    task automatic do_reset();
        #3;
        rst_i = 1'b1;
        bus.evt_valid_i = 1'b1;
        set_c(0);
        #1;
        chk("rst_wt", 64'(bus.events_wt_o), 64'(0));
        chk("rst_da", bus.events_da_o, 64'(0));
        chk("rst_ready", 64'(bus.evt_ready_o), 64'(1));
        chk("rst_fill", 64'(bus.fill_o), 64'(0));
        P = 0; Cd1 = 0; Cs = 0; m_fill = 0; accepted = 0;
        pushed.delete();
        ptime.delete();
        repeat (2) @(posedge clk_i);
        #2;
        chk("rst_hold_wt", 64'(bus.events_wt_o), 64'(0));
        chk("rst_hold_ready", 64'(bus.evt_ready_o), 64'(1));
        bus.evt_valid_i = 1'b0;
        rst_i = 1'b0;
    endtask

    initial begin
        int guard;
        for (int k = 0; k < 8; k++)
            tbl[k] = '{1'b1, EW'(8'h10 + k), k < 7, BW'((1 << (k + 1)) - 1), k};
        tbl[8] = '{1'b1, 8'h18, 1'b0, 8'hFF, 8};
        tbl[9] = '{1'b1, 8'h18, 1'b0, 8'hFF, 8};
        P = 0; C = 0; Cd1 = 0; Cs = 0; m_fill = 0; now = 0; accepted = 0;
        bus.evt_valid_i = 1'b0;
        bus.evt_data_i = '0;
        bus.events_rp_i = '0;
        repeat (2) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        chk("init_ready", 64'(bus.evt_ready_o), 64'(1));
        chk("init_fill", 64'(bus.fill_o), 64'(0));

        // single event and its credit
        bus.evt_valid_i = 1'b1;
        bus.evt_data_i = 8'hA5;
        tick();
        bus.evt_valid_i = 1'b0;
        chk("single_wt", 64'(bus.events_wt_o), 64'h01);
        chk("single_da", 64'(bus.events_da_o[7:0]), 64'hA5);
        tick();
        chk("single_fill", 64'(bus.fill_o), 64'(1));
        set_c(1);
        repeat (2) tick();
        chk("credit_fill_lag", 64'(bus.fill_o), 64'(1));
        tick();
        chk("credit_fill", 64'(bus.fill_o), 64'(0));

        // mid-stream reset, then fill to full with a stalled 9th event
        bus.evt_valid_i = 1'b1;
        bus.evt_data_i = 8'h33;
        tick();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            bus.evt_valid_i = tbl[k].v;
            bus.evt_data_i = tbl[k].d;
            tick();
            chk($sformatf("tbl%0d_wt", k), 64'(bus.events_wt_o), 64'(tbl[k].wt));
            chk($sformatf("tbl%0d_ready", k), 64'(bus.evt_ready_o), 64'(tbl[k].r));
            chk($sformatf("tbl%0d_fill", k), 64'(bus.fill_o), 64'(tbl[k].f));
        end
        chk("full_da", bus.events_da_o, 64'h1716151413121110);

        // credit from full and wrap to slot 0
        bus.evt_valid_i = 1'b0;
        set_c(1);
        tick();
        chk("cr_ready_c1", 64'(bus.evt_ready_o), 64'(0));
        tick();
        chk("cr_ready_c2", 64'(bus.evt_ready_o), 64'(1));
        bus.evt_valid_i = 1'b1;
        bus.evt_data_i = 8'h20;
        tick();
        bus.evt_valid_i = 1'b0;
        chk("wrap_wt", 64'(bus.events_wt_o), 64'hFE);
        chk("wrap_da0", 64'(bus.events_da_o[7:0]), 64'h20);
        chk("wrap_ready", 64'(bus.evt_ready_o), 64'(0));

        // second lap with timely credits
        do_reset();
        bus.evt_valid_i = 1'b1;
        bus.evt_data_i = EW'($urandom);
        guard = 0;
        while (P < 16 && guard < 200) begin
            if (C < P) set_c(C + 1);
            tick();
            if (accepted) bus.evt_data_i = EW'($urandom);
            bus.evt_valid_i = (P < 16);
            guard++;
        end
        bus.evt_valid_i = 1'b0;
        chk("lap_count", 64'(P), 64'(16));
        chk("lap_wt", 64'(bus.events_wt_o), 64'h00);
        guard = 0;
        while (C < P && guard < 50) begin
            set_c(C + 1);
            tick();
            guard++;
        end
        repeat (3) tick();
        chk("lap_drained_fill", 64'(bus.fill_o), 64'(0));

        // random traffic with a consumer lagging at least 4 cycles
        do_reset();
        guard = 0;
        while (P < 1000 && guard < 8000) begin
            if (!(bus.evt_valid_i && !accepted)) begin
                bus.evt_valid_i = ($urandom_range(3) != 0);
                bus.evt_data_i = EW'($urandom);
            end
            if (C < P && ptime[C] + 4 <= now && $urandom_range(2) != 0) begin
                chk("order", 64'(bus.events_da_o[(C % BW)*EW +: EW]), 64'(pushed[C]));
                set_c(C + 1);
            end
            tick();
            guard++;
        end
        chk("rand_done", 64'(P >= 1000), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
